// File: rtl/fx_pkg.sv
// Shared types and constants for the fixed-point product accumulation path.
package fx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_ROUND = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  localparam int PROD_W_DEF = 32;
  localparam int ACC_W_DEF  = 40;
  localparam int FRAC_DEF   = 8;
  localparam int OUT_W_DEF  = 16;
  localparam int LEN_W_DEF  = 8;

  // Value of one half LSB after dropping frac bits; added before the shift to round half up.
  function automatic logic [63:0] half_lsb(input int frac);
    return 64'd1 << (frac - 1);
  endfunction

endpackage

// File: rtl/fx_round_sat.sv
// Combinational rescale: drop FRAC bits with round-half-up, then saturate to OUT_W bits.
module fx_round_sat
  import fx_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [OUT_W-1:0] result_o,
  output logic             sat_o
);

  localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(half_lsb(FRAC));

  logic [ACC_W:0] sum;
  logic [ACC_W:0] r;

  // One extra bit so the rounding add can never wrap.
  assign sum      = {1'b0, acc_i} + HALF;
  assign r        = sum >> FRAC;
  assign sat_o    = |r[ACC_W:OUT_W];
  assign result_o = sat_o ? {OUT_W{1'b1}} : r[OUT_W-1:0];

endmodule

// File: rtl/prod_accum.sv
// Accumulates a programmed number of unsigned products, then rounds and saturates the sum
// into a held valid/ready result.
//
// state | meaning
// IDLE  | waiting for start with nonzero len
// ACCUM | accepting product beats until cnt reaches zero
// ROUND | registering the rounded/saturated result
// OUT   | result presented until out_ready
module prod_accum
  import fx_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_prod,
  output logic              in_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  input  logic              out_ready
);

  if (ACC_W < PROD_W + LEN_W) begin : g_acc_w_chk
    $error("prod_accum: ACC_W must be at least PROD_W + LEN_W");
  end
  if (FRAC < 1) begin : g_frac_chk
    $error("prod_accum: FRAC must be at least 1");
  end

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_sat_q, out_sat_d;
  logic [OUT_W-1:0]   rs_result;
  logic               rs_sat;

  fx_round_sat #(
    .ACC_W (ACC_W),
    .FRAC  (FRAC),
    .OUT_W (OUT_W)
  ) u_round_sat (
    .acc_i    (acc_q),
    .result_o (rs_result),
    .sat_o    (rs_sat)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      S_IDLE: begin
        if (start && (len != '0)) begin
          acc_d   = '0;
          cnt_d   = len;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d = acc_q + ACC_W'(in_prod);
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        out_data_d = rs_result;
        out_sat_d  = rs_sat;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_data_q;
  // Clip flag is only meaningful alongside a presented result.
  assign out_sat   = out_sat_q & out_valid;

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum with a result scoreboard.
module tb_prod_accum;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        busy;
  logic        in_valid;
  logic [31:0] in_prod;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_sat;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  logic [16:0] sb[$];

  prod_accum dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_prod   (in_prod),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model(input longint unsigned s);
    longint unsigned r;
    r = (s + 64'd128) >> 8;
    if (r > 64'd65535) return {1'b1, 16'hFFFF};
    return {1'b0, r[15:0]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_job(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    cyc();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, {31'd0, (l != 8'd0)});
    chk("in_ready_after_start", {31'd0, in_ready}, {31'd0, (l != 8'd0)});
  endtask

  task automatic beat(input logic [31:0] p, input int bubbles);
    in_valid = 1'b0;
    repeat (bubbles) cyc();
    in_valid = 1'b1;
    in_prod  = p;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic collect();
    int n;
    logic [16:0] e;
    n = 0;
    while (!out_valid && n < 50) begin
      cyc();
      n++;
    end
    chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    else e = 'x;
    chk("out_data", {16'd0, out_data}, {16'd0, e[15:0]});
    chk("out_sat", {31'd0, out_sat}, {31'd0, e[16]});
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("busy_after_hs", {31'd0, busy}, 32'd0);
    chk("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;
    @(negedge clk);
    cyc();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_sat", {31'd0, out_sat}, 32'd0);
    rst = 1'b0;
    cyc();

    // len=1, 1.5 rounds up to 2; check one-cycle ROUND latency
    sb.push_back(model(64'h180));
    start_job(8'd1);
    beat(32'h0000_0180, 0);
    chk("lat_round_out_valid", {31'd0, out_valid}, 32'd0);
    chk("lat_round_in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    collect();

    // len=3 with 2-cycle bubbles between beats
    sb.push_back(model(64'h600));
    start_job(8'd3);
    beat(32'h100, 0);
    beat(32'h200, 2);
    in_valid = 1'b0;
    cyc(); cyc();
    chk("bubble_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bubble_no_out", {31'd0, out_valid}, 32'd0);
    beat(32'h300, 0);
    collect();

    // saturation from full-scale products
    sb.push_back(model(64'h1_FFFF_FFFE));
    start_job(8'd2);
    beat(32'hFFFF_FFFF, 0);
    beat(32'hFFFF_FFFF, 1);
    collect();

    // boundary just below and at saturation
    sb.push_back(model(64'hFF_FF7F));
    start_job(8'd1);
    beat(32'h00FF_FF7F, 0);
    collect();
    sb.push_back(model(64'hFF_FF80));
    start_job(8'd1);
    beat(32'h00FF_FF80, 0);
    collect();
    sb.push_back(model(64'h17F));
    start_job(8'd1);
    beat(32'h0000_017F, 0);
    collect();

    // held result with out_ready low and start pulsed during OUT
    sb.push_back(model(64'h12345));
    start_job(8'd1);
    beat(32'h0001_2345, 0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      len   = 8'd2;
      cyc();
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_out_data", {16'd0, out_data}, 32'h123);
      chk("hold_out_sat", {31'd0, out_sat}, 32'd0);
    end
    start = 1'b1;
    collect();
    start = 1'b0;
    cyc();
    chk("hs_start_ignored", {31'd0, busy}, 32'd0);

    // len=0 start is ignored
    start_job(8'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("len0_busy", {31'd0, busy}, 32'd0);
      chk("len0_in_ready", {31'd0, in_ready}, 32'd0);
      chk("len0_out_valid", {31'd0, out_valid}, 32'd0);
    end

    // abort mid-job with async reset, then a clean job
    start_job(8'd4);
    beat(32'h1000, 0);
    beat(32'h1000, 0);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_out_data", {16'd0, out_data}, 32'd0);
    chk("abort_out_sat", {31'd0, out_sat}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    sb.push_back(model(64'h100));
    start_job(8'd1);
    beat(32'h0000_0100, 0);
    collect();

    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
Name: prod_accum

Overview:
- Downstream consumer of the 16x16 fixed-point multiplier's 32-bit product stream.
- Accumulates a programmed number of products (dot-product / MAC reduction) into a wide accumulator.
- Then rescales by FRAC bits with round-half-up and saturates to a 16-bit result.
- Result is presented on a valid/ready output port and held until consumed.

Parameters:
- PROD_W, 32, width of incoming unsigned product
- ACC_W, 40, accumulator width; 2^(ACC_W-PROD_W) ≥ max len, so no accumulator overflow
- FRAC, 8, fractional bits dropped at rescale (must be ≥1)
- OUT_W, 16, width of saturated result
- LEN_W, 8, width of len port (max 255 products per job)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  job start pulse, sampled only in IDLE
- len  in  LEN_W  number of products in job, sampled with start
- busy  out  1  high in any state other than IDLE
- in_valid  in  1  in_prod valid
- in_prod  in  PROD_W  unsigned product from multiplier
- in_ready  out  1  high only in ACCUM
- out_valid  out  1  result valid
- out_data  out  OUT_W  rounded, saturated result
- out_sat  out  1  result was clipped to all-ones
- out_ready  in  1  downstream accepts result

Behaviour:
- Reset (async, immediate): state=IDLE, acc=0, cnt=0; busy, in_ready, out_valid, out_sat=0; out_data=0. Reset mid-job discards the in-flight job; no partial result is emitted.
- States: IDLE, ACCUM, ROUND, OUT.
- IDLE:
  - start=1 & len≠0 → acc<=0, cnt<=len, next ACCUM.
  - start=1 & len=0 → ignored, stays IDLE.
- ACCUM:
  - in_ready=1. A beat is accepted on in_valid & in_ready.
  - On each beat: acc <= acc + zero-extended in_prod; cnt <= cnt-1.
  - Beat accepted while cnt==1 → next ROUND.
  - Cycles with in_valid=0 are bubbles: no change to acc or cnt.
- ROUND:
  - in_ready=0.
  - r = (acc + 2^(FRAC-1)) >> FRAC, computed in ACC_W+1 bits.
  - If r > 2^OUT_W-1: out_data <= all-ones, out_sat <= 1. Else out_data <= r[OUT_W-1:0], out_sat <= 0.
  - out_valid <= 1; next OUT.
- OUT:
  - out_valid=1; out_data and out_sat held stable while out_ready=0.
  - out_valid & out_ready → out_valid <= 0, next IDLE.
- Latency: last beat accepted at edge k → out_valid=1 after edge k+1.
- Throughput: minimum job period is len+3 cycles with no back-to-back overlap.
- start outside IDLE is ignored, including the OUT handshake cycle.
- Unsigned arithmetic only. in_prod is always zero-extended. A width overflow of acc is impossible by parameter rule; checked by an elaboration assertion: ACC_W ≥ PROD_W+LEN_W.

Decomposition:
- Package fx_pkg holds:
  - state enum type (IDLE, ACCUM, ROUND, OUT)
  - default FRAC, PROD_W, ACC_W, OUT_W, LEN_W constants
  - rounding-constant function half_lsb(FRAC)
- One combinational sub-module, fx_round_sat (ACC_W, FRAC, OUT_W in; result and sat out). It is reusable by other rescale stages.
- prod_accum instantiates fx_round_sat and registers its outputs in ROUND.

Test Plan:
- len=1, in_prod=0x0000_0180 → out_data=0x0002, out_sat=0, out_valid one cycle after ROUND entry (round-half-up: 1.5→2).
- len=3, in_prod 0x100, 0x200, 0x300 with in_valid bubbles of 2 cycles between beats → acc=0x600, out_data=0x0006, cnt ignores bubbles.
- len=2, in_prod=0xFFFF_FFFF twice → out_data=0xFFFF, out_sat=1.
- Result pending, out_ready low for 5 cycles, start pulsed during OUT → out_data/out_sat stable, out_valid held, start ignored. Then out_ready=1 → IDLE, busy=0.
- start with len=0 → busy stays 0, in_ready stays 0, no out_valid.
- len=4, rst asserted after 2 beats → all outputs 0 immediately. New job len=1, in_prod=0x0000_0100 → out_data=0x0001 (no residue from aborted job).
